// File: rtl/kbd_rx_fifo.sv
// -----------------------------------------------------------------------------
// kbd_rx_fifo
//
// Receive buffer between the UART receiver and the PDP-8 keyboard IOT logic.
// Every byte strobed out by the receiver is captured into a small circular
// FIFO. The keyboard flag is raised while data is waiting. The CPU-side IOTs
// consume the bytes: KSF tests o_Flag, KRB takes o_Data and pulses i_Pop,
// and KCF pulses i_Flush. A sticky overrun bit records bytes that were lost
// because the buffer was full.
//
// Parameters
//   DEPTH_LOG2   FIFO depth is 2**DEPTH_LOG2 entries (legal range 1..6)
//
// Ports
//   i_Clock      system clock, rising edge
//   i_Reset_n    asynchronous active-low reset
//   i_RX_DV      one-cycle byte-valid strobe from the UART receiver
//   i_RX_Byte    received byte, sampled only when i_RX_DV=1
//   i_Pop        KRB read strobe, discards the head entry
//   i_Flush      KCF strobe, empties the FIFO and clears overrun
//   o_Flag       1 while the FIFO is non-empty (KSF skip condition)
//   o_Data       head entry, 8'h00 when empty
//   o_Count      number of stored entries, 0..2**DEPTH_LOG2
//   o_Full       1 when o_Count equals the depth
//   o_Overrun    sticky, set when a byte is dropped
//
// Build option
//   KBD_MARK_BIT7_EN  when defined, bit 7 of every stored byte is forced to 1
//                     (ASR-33 mark parity). Otherwise bytes are stored as
//                     received. Flag, count and overrun behave the same in
//                     both builds.
// -----------------------------------------------------------------------------
module kbd_rx_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset_n,
    input  logic                  i_RX_DV,
    input  logic [7:0]            i_RX_Byte,
    input  logic                  i_Pop,
    input  logic                  i_Flush,
    output logic                  o_Flag,
    output logic [7:0]            o_Data,
    output logic [DEPTH_LOG2:0]   o_Count,
    output logic                  o_Full,
    output logic                  o_Overrun
);

    localparam int                    DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    // Storage array; holds data only, so it carries no reset.
    logic [7:0]            r_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_flag;
    logic                  r_full;
    logic                  r_overrun;

    logic                  w_pop_ok;
    logic                  w_push_ok;
    logic                  w_drop;
    logic [7:0]            w_store_byte;
    logic [DEPTH_LOG2:0]   w_count_next;

    // Byte conditioning applied on the way into the array.
`ifdef KBD_MARK_BIT7_EN
    assign w_store_byte = {1'b1, i_RX_Byte[6:0]};
`else
    assign w_store_byte = i_RX_Byte;
`endif

    // Flush dominates everything. A pop only counts when something is
    // stored; an accepted pop frees a slot, so a push into a full FIFO in
    // the same cycle is still accepted and no overrun results.
    assign w_pop_ok  = i_Pop & r_flag & ~i_Flush;
    assign w_push_ok = i_RX_DV & ~i_Flush & (~r_full | w_pop_ok);
    assign w_drop    = i_RX_DV & ~i_Flush & r_full & ~w_pop_ok;

    always_comb begin
        w_count_next = r_count;
        if (i_Flush) begin
            w_count_next = '0;
        end else begin
            case ({w_push_ok, w_pop_ok})
                2'b10:   w_count_next = r_count + CNT_ONE;
                2'b01:   w_count_next = r_count - CNT_ONE;
                default: w_count_next = r_count;
            endcase
        end
    end

    // Control state: pointers, occupancy and the registered status outputs.
    // Flag and full are registered copies derived from the next count so the
    // outputs come straight from flops.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_flag    <= 1'b0;
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_flag  <= (w_count_next != '0);
            r_full  <= (w_count_next == DEPTH_CNT);

            if (i_Flush) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_overrun <= 1'b0;
            end else begin
                if (w_push_ok) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_pop_ok) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
                if (w_drop) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_store_byte;
        end
    end

    // Head presentation depends only on registered state; an empty FIFO
    // shows zero rather than stale array contents.
    assign o_Data    = r_flag ? r_mem[r_rd_ptr] : 8'h00;
    assign o_Flag    = r_flag;
    assign o_Count   = r_count;
    assign o_Full    = r_full;
    assign o_Overrun = r_overrun;

endmodule

// File: tb/tb_kbd_rx_fifo.sv
module tb_kbd_rx_fifo;

    localparam int DL2   = 3;
    localparam int DEPTH = 1 << DL2;

    logic           clk;
    logic           rst_n;
    logic           i_RX_DV;
    logic [7:0]     i_RX_Byte;
    logic           i_Pop;
    logic           i_Flush;
    logic           o_Flag;
    logic [7:0]     o_Data;
    logic [DL2:0]   o_Count;
    logic           o_Full;
    logic           o_Overrun;

    int total = 0;
    int bad   = 0;

    // Reference model: a plain queue of stored bytes plus a sticky bit.
    logic [7:0] mq[$];
    logic       m_ov;

    kbd_rx_fifo #(.DEPTH_LOG2(DL2)) dut (
        .i_Clock   (clk),
        .i_Reset_n (rst_n),
        .i_RX_DV   (i_RX_DV),
        .i_RX_Byte (i_RX_Byte),
        .i_Pop     (i_Pop),
        .i_Flush   (i_Flush),
        .o_Flag    (o_Flag),
        .o_Data    (o_Data),
        .o_Count   (o_Count),
        .o_Full    (o_Full),
        .o_Overrun (o_Overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mk(input logic [7:0] b);
`ifdef KBD_MARK_BIT7_EN
        return b | 8'h80;
`else
        return b;
`endif
    endfunction

    function automatic void model_step(input logic dv, input logic [7:0] b,
                                       input logic pop, input logic flush);
        bit was_full;
        bit popped;
        if (flush) begin
            mq.delete();
            m_ov = 1'b0;
            return;
        end
        was_full = (mq.size() == DEPTH);
        popped   = pop && (mq.size() > 0);
        if (popped) void'(mq.pop_front());
        if (dv) begin
            if (!was_full || popped) mq.push_back(mk(b));
            else m_ov = 1'b1;
        end
    endfunction

    function automatic logic [7:0] m_data();
        return (mq.size() > 0) ? mq[0] : 8'h00;
    endfunction

    // Apply one cycle of strobes, advance the model, sample 1 ns after the edge.
    task automatic step(input logic dv, input logic [7:0] b,
                        input logic pop, input logic flush);
        i_RX_DV   = dv;
        i_RX_Byte = b;
        i_Pop     = pop;
        i_Flush   = flush;
        @(posedge clk);
        model_step(dv, b, pop, flush);
        #1;
        i_RX_DV = 1'b0;
        i_Pop   = 1'b0;
        i_Flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_RX_DV = 0; i_RX_Byte = 0; i_Pop = 0; i_Flush = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete(); m_ov = 1'b0;
        @(posedge clk); #1;
        total++; if (o_Flag !== 1'b0) begin bad++; $display("FAIL reset_flag got=%b exp=0", o_Flag); end
        total++; if (o_Count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", o_Count); end
        total++; if (o_Full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", o_Full); end
        total++; if (o_Overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", o_Overrun); end
        total++; if (o_Data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", o_Data); end
    endtask

    task automatic test_single();
        step(1, 8'h41, 0, 0);
        total++; if (o_Flag !== 1'b1) begin bad++; $display("FAIL single_flag got=%b exp=1", o_Flag); end
        total++; if (o_Count !== 4'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", o_Count); end
        total++; if (o_Data !== mk(8'h41)) begin bad++; $display("FAIL single_data got=%h exp=%h", o_Data, mk(8'h41)); end
        step(0, 8'h00, 1, 0);
        total++; if (o_Flag !== 1'b0) begin bad++; $display("FAIL single_pop_flag got=%b exp=0", o_Flag); end
        total++; if (o_Data !== 8'h00) begin bad++; $display("FAIL single_pop_data got=%h exp=00", o_Data); end
    endtask

    task automatic test_order_wrap();
        logic [7:0] b;
        step(0, 8'h00, 0, 1);
        for (int i = 1; i <= 8; i++) begin b = 8'(i); step(1, b, 0, 0); end
        total++; if (o_Full !== 1'b1) begin bad++; $display("FAIL wrap_full got=%b exp=1", o_Full); end
        repeat (4) step(0, 8'h00, 1, 0);
        for (int i = 9; i <= 12; i++) begin b = 8'(i); step(1, b, 0, 0); end
        for (int i = 5; i <= 12; i++) begin
            b = mk(8'(i));
            total++; if (o_Data !== b) begin bad++; $display("FAIL wrap_seq got=%h exp=%h", o_Data, b); end
            step(0, 8'h00, 1, 0);
        end
        total++; if (o_Count !== 4'd0) begin bad++; $display("FAIL wrap_count got=%0d exp=0", o_Count); end
        total++; if (o_Overrun !== 1'b0) begin bad++; $display("FAIL wrap_overrun got=%b exp=0", o_Overrun); end
    endtask

    task automatic test_overrun();
        logic [7:0] b;
        step(0, 8'h00, 0, 1);
        for (int i = 0; i < 8; i++) begin b = 8'h10 + 8'(i); step(1, b, 0, 0); end
        total++; if (o_Overrun !== 1'b0) begin bad++; $display("FAIL ovr_early got=%b exp=0", o_Overrun); end
        step(1, 8'hFF, 0, 0);
        total++; if (o_Full !== 1'b1) begin bad++; $display("FAIL ovr_full got=%b exp=1", o_Full); end
        total++; if (o_Count !== 4'd8) begin bad++; $display("FAIL ovr_count got=%0d exp=8", o_Count); end
        total++; if (o_Overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", o_Overrun); end
        total++; if (o_Data !== mk(8'h10)) begin bad++; $display("FAIL ovr_head got=%h exp=%h", o_Data, mk(8'h10)); end
        for (int i = 0; i < 8; i++) begin
            b = mk(8'h10 + 8'(i));
            total++; if (o_Data !== b) begin bad++; $display("FAIL ovr_drain got=%h exp=%h", o_Data, b); end
            step(0, 8'h00, 1, 0);
        end
        total++; if (o_Overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", o_Overrun); end
        step(0, 8'h00, 0, 1);
        total++; if (o_Overrun !== 1'b0) begin bad++; $display("FAIL ovr_flush got=%b exp=0", o_Overrun); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin b = 8'h20 + 8'(i); step(1, b, 0, 0); end
        step(1, 8'h3A, 1, 0);
        total++; if (o_Count !== 4'd8) begin bad++; $display("FAIL sim_full_count got=%0d exp=8", o_Count); end
        total++; if (o_Overrun !== 1'b0) begin bad++; $display("FAIL sim_full_ovr got=%b exp=0", o_Overrun); end
        total++; if (o_Data !== mk(8'h21)) begin bad++; $display("FAIL sim_full_head got=%h exp=%h", o_Data, mk(8'h21)); end
        repeat (7) step(0, 8'h00, 1, 0);
        total++; if (o_Data !== mk(8'h3A)) begin bad++; $display("FAIL sim_full_last got=%h exp=%h", o_Data, mk(8'h3A)); end
        step(0, 8'h00, 1, 0);
        step(1, 8'h55, 1, 0);
        total++; if (o_Count !== 4'd1) begin bad++; $display("FAIL sim_empty_count got=%0d exp=1", o_Count); end
        total++; if (o_Data !== mk(8'h55)) begin bad++; $display("FAIL sim_empty_data got=%h exp=%h", o_Data, mk(8'h55)); end
        for (int i = 0; i < 8; i++) step(1, 8'h60, 0, 0);
        step(1, 8'h77, 0, 1);
        total++; if (o_Count !== 4'd0) begin bad++; $display("FAIL sim_flush_count got=%0d exp=0", o_Count); end
        total++; if (o_Overrun !== 1'b0) begin bad++; $display("FAIL sim_flush_ovr got=%b exp=0", o_Overrun); end
        total++; if (o_Flag !== 1'b0) begin bad++; $display("FAIL sim_flush_flag got=%b exp=0", o_Flag); end
    endtask

    task automatic test_empty_pop();
        step(0, 8'h00, 0, 1);
        repeat (3) step(0, 8'h00, 1, 0);
        total++; if (o_Count !== 4'd0) begin bad++; $display("FAIL epop_count got=%0d exp=0", o_Count); end
        step(1, 8'h5A, 0, 0);
        step(1, 8'hA5, 0, 0);
        total++; if (o_Data !== mk(8'h5A)) begin bad++; $display("FAIL epop_data0 got=%h exp=%h", o_Data, mk(8'h5A)); end
        step(0, 8'h00, 1, 0);
        total++; if (o_Data !== mk(8'hA5)) begin bad++; $display("FAIL epop_data1 got=%h exp=%h", o_Data, mk(8'hA5)); end
        total++; if (o_Count !== 4'd1) begin bad++; $display("FAIL epop_count1 got=%0d exp=1", o_Count); end
    endtask

    task automatic test_random();
        logic       dv, pop, fl;
        logic [7:0] b;
        for (int n = 0; n < 400; n++) begin
            dv  = ($urandom_range(0, 99) < 55);
            pop = ($urandom_range(0, 99) < 40);
            fl  = ($urandom_range(0, 99) < 3);
            b   = 8'($urandom);
            step(dv, b, pop, fl);
            total++;
            if (o_Count !== (DL2 + 1)'(mq.size()) || o_Flag !== (mq.size() != 0) ||
                o_Full !== (mq.size() == DEPTH) || o_Overrun !== m_ov || o_Data !== m_data()) begin
                bad++;
                $display("FAIL rand_%0d got cnt=%0d flg=%b full=%b ovr=%b data=%h exp cnt=%0d ovr=%b data=%h",
                         n, o_Count, o_Flag, o_Full, o_Overrun, o_Data, mq.size(), m_ov, m_data());
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] b;
        step(0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) begin b = 8'h70 + 8'(i); step(1, b, 0, 0); end
        total++; if (o_Count !== 4'd5) begin bad++; $display("FAIL arst_pre got=%0d exp=5", o_Count); end
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete(); m_ov = 1'b0;
        total++; if (o_Count !== 4'd0) begin bad++; $display("FAIL arst_count got=%0d exp=0", o_Count); end
        total++; if (o_Flag !== 1'b0) begin bad++; $display("FAIL arst_flag got=%b exp=0", o_Flag); end
        total++; if (o_Data !== 8'h00) begin bad++; $display("FAIL arst_data got=%h exp=00", o_Data); end
        total++; if (o_Full !== 1'b0 || o_Overrun !== 1'b0) begin bad++; $display("FAIL arst_status got=%b%b exp=00", o_Full, o_Overrun); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        step(1, 8'h33, 0, 0);
        total++; if (o_Count !== 4'd1 || o_Data !== mk(8'h33)) begin bad++; $display("FAIL arst_after got=%0d/%h exp=1/%h", o_Count, o_Data, mk(8'h33)); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_order_wrap();
        test_overrun();
        test_simultaneous();
        test_empty_pop();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
